// File: rtl/reg_writeback_pkg.sv
// Shared widths, link-register index and write-port state encoding for reg_writeback.
package reg_writeback_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int REGWIDTH_DEF  = 4;
  localparam int LINK_REG      = 15;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HELD  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_ldq.sv
// In-order queue of outstanding load destinations; head readable combinationally, push/pop take effect at posedge.
// Backpressure: full flag only; a pop on an empty queue with a same-cycle push is a bypass and leaves state untouched.
module wb_ldq #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [W-1:0]         push_rd,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH-1:0]     ent_vld,
  output logic [DEPTH*W-1:0]   ent_rd
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;
  logic [PW-1:0] off;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign head    = mem[rptr];
  assign do_push = push && !(pop && empty);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_rd;
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    off     = '0;
    ent_vld = '0;
    ent_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rptr;
      ent_vld[i] = ({1'b0, off} < count);
      ent_rd[i*W +: W] = mem[i];
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU results and load returns onto one registered register-file write port; one-cycle latency.
// Memory returns cannot stall, so a colliding ALU result parks in a one-entry skid and alu_ready drops while it is held.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int REGWIDTH  = REGWIDTH_DEF,
  parameter int LDQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REGWIDTH-1:0]  alu_rd,
  input  logic [DATAWIDTH-1:0] alu_data,
  input  logic [DATAWIDTH-1:0] alu_pc,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REGWIDTH-1:0]  ld_rd,
  input  logic                 mem_rvalid,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 rf_write,
  output logic [REGWIDTH-1:0]  rf_rdst,
  output logic [DATAWIDTH-1:0] rf_wdata,
  output logic [DATAWIDTH-1:0] rf_pc,
  input  logic [REGWIDTH-1:0]  rq_src,
  input  logic [REGWIDTH-1:0]  rq_dst,
  output logic                 hazard,
  output logic                 ldq_err
);

  wb_state_e                state, state_nxt;
  logic                     live;
  logic                     ldq_full, ldq_empty;
  logic [REGWIDTH-1:0]      ldq_head;
  logic [LDQ_DEPTH-1:0]     ent_vld;
  logic [LDQ_DEPTH*REGWIDTH-1:0] ent_rd;
  logic                     alu_hs, ld_hs, mem_wr;
  logic [REGWIDTH-1:0]      mem_rd;
  logic [REGWIDTH-1:0]      park_rd;
  logic [DATAWIDTH-1:0]     park_data, park_pc;
  logic                     park_load;
  logic                     sel_vld;
  logic [REGWIDTH-1:0]      sel_rd;
  logic [DATAWIDTH-1:0]     sel_data, sel_pc;
  logic                     src_hit, dst_hit;

  assign alu_ready = live && (state == WB_EMPTY);
  assign ld_ready  = live && !ldq_full;
  assign alu_hs    = alu_valid && alu_ready;
  assign ld_hs     = ld_valid && ld_ready;
  // A return into an empty queue is only legal when the matching load is issued this same cycle.
  assign mem_wr    = mem_rvalid && (!ldq_empty || ld_hs);
  assign mem_rd    = ldq_empty ? ld_rd : ldq_head;

  wb_ldq #(.DEPTH(LDQ_DEPTH), .W(REGWIDTH)) u_ldq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ld_hs),
    .push_rd (ld_rd),
    .pop     (mem_wr),
    .head    (ldq_head),
    .full    (ldq_full),
    .empty   (ldq_empty),
    .ent_vld (ent_vld),
    .ent_rd  (ent_rd)
  );

  always_comb begin
    state_nxt = state;
    park_load = 1'b0;
    sel_vld   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    sel_pc    = '0;
    if (mem_wr) begin
      sel_vld  = 1'b1;
      sel_rd   = mem_rd;
      sel_data = mem_rdata;
      if (state == WB_EMPTY && alu_hs) begin
        park_load = 1'b1;
        state_nxt = WB_HELD;
      end
    end else if (state == WB_HELD) begin
      sel_vld   = 1'b1;
      sel_rd    = park_rd;
      sel_data  = park_data;
      sel_pc    = park_pc;
      state_nxt = WB_EMPTY;
    end else if (alu_hs) begin
      sel_vld  = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
      sel_pc   = alu_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WB_EMPTY;
      live      <= 1'b0;
      park_rd   <= '0;
      park_data <= '0;
      park_pc   <= '0;
      rf_write  <= 1'b0;
      rf_rdst   <= '0;
      rf_wdata  <= '0;
      rf_pc     <= '0;
      ldq_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      live     <= 1'b1;
      rf_write <= sel_vld && (sel_rd != '0);
      if (park_load) begin
        park_rd   <= alu_rd;
        park_data <= alu_data;
        park_pc   <= alu_pc;
      end
      if (sel_vld) begin
        rf_rdst  <= sel_rd;
        rf_wdata <= sel_data;
        rf_pc    <= (sel_rd == REGWIDTH'(LINK_REG)) ? sel_pc : '0;
      end
      if (mem_rvalid && ldq_empty && !ld_hs) ldq_err <= 1'b1;
    end
  end

  always_comb begin
    src_hit = (state == WB_HELD) && (park_rd == rq_src);
    dst_hit = (state == WB_HELD) && (park_rd == rq_dst);
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (ent_vld[i] && ent_rd[i*REGWIDTH +: REGWIDTH] == rq_src) src_hit = 1'b1;
      if (ent_vld[i] && ent_rd[i*REGWIDTH +: REGWIDTH] == rq_dst) dst_hit = 1'b1;
    end
    hazard = (src_hit && rq_src != '0) || (dst_hit && rq_dst != '0);
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Drives reg_writeback with directed and random traffic and compares against a queue-based reference model.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, mem_rvalid = 1'b0;
  logic [3:0]  alu_rd = '0, ld_rd = '0, rq_src = '0, rq_dst = '0;
  logic [15:0] alu_data = '0, alu_pc = '0, mem_rdata = '0;
  logic        alu_ready, ld_ready, rf_write, hazard, ldq_err;
  logic [3:0]  rf_rdst;
  logic [15:0] rf_wdata, rf_pc;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding loads in issue order, an optional parked ALU result.
  int          lq[$];
  bit          park_v = 0;
  int          park_rd, park_data, park_pc;
  bit          err_m = 0;
  bit          live_m = 0;

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_pc(alu_pc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_write(rf_write), .rf_rdst(rf_rdst), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .rq_src(rq_src), .rq_dst(rq_dst), .hazard(hazard), .ldq_err(ldq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_haz(input int r);
    if (r == 0) return 0;
    if (park_v && park_rd == r) return 1;
    foreach (lq[i]) if (lq[i] == r) return 1;
    return 0;
  endfunction

  task automatic set_in(input bit av, input int ar, input int ad, input int ap,
                        input bit lv, input int lr, input bit mv, input int md);
    alu_valid = av; alu_rd = 4'(ar); alu_data = 16'(ad); alu_pc = 16'(ap);
    ld_valid = lv; ld_rd = 4'(lr); mem_rvalid = mv; mem_rdata = 16'(md);
  endtask

  // One clock: check ready/hazard before the edge, advance the model, check the write port after.
  task automatic step();
    bit a_rdy, l_rdy, alu_hs, ld_hs, wr;
    int wrd, wdat, wpc;
    #1;
    a_rdy = live_m && !park_v;
    l_rdy = live_m && (lq.size() < 4);
    chk("alu_ready", 32'(alu_ready), 32'(a_rdy));
    chk("ld_ready", 32'(ld_ready), 32'(l_rdy));
    chk("hazard", 32'(hazard), 32'(exp_haz(int'(rq_src)) || exp_haz(int'(rq_dst))));
    alu_hs = alu_valid && a_rdy;
    ld_hs  = ld_valid && l_rdy;
    if (ld_hs) lq.push_back(int'(ld_rd));
    wr = 0; wrd = 0; wdat = 0; wpc = 0;
    if (mem_rvalid) begin
      if (lq.size() == 0) err_m = 1;
      else begin
        wr = 1; wrd = lq.pop_front(); wdat = int'(mem_rdata);
      end
    end
    if (wr) begin
      if (alu_hs) begin
        park_v = 1; park_rd = int'(alu_rd); park_data = int'(alu_data); park_pc = int'(alu_pc);
      end
    end else if (park_v) begin
      wr = 1; wrd = park_rd; wdat = park_data; wpc = park_pc; park_v = 0;
    end else if (alu_hs) begin
      wr = 1; wrd = int'(alu_rd); wdat = int'(alu_data); wpc = int'(alu_pc);
    end
    @(posedge clk);
    #1;
    live_m = 1;
    chk("rf_write", 32'(rf_write), 32'(wr && wrd != 0));
    if (wr && wrd != 0) begin
      chk("rf_rdst", 32'(rf_rdst), 32'(wrd));
      chk("rf_wdata", 32'(rf_wdata), 32'(wdat));
      chk("rf_pc", 32'(rf_pc), (wrd == 15) ? 32'(wpc) : 32'd0);
    end
    chk("ldq_err", 32'(ldq_err), 32'(err_m));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_ldq_err", 32'(ldq_err), 32'd0);
    lq.delete(); park_v = 0; err_m = 0; live_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    apply_reset();
    chk("rst_rf_rdst", 32'(rf_rdst), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    step();

    // ALU r3 = 0x1234
    set_in(1, 3, 'h1234, 0, 0, 0, 0, 0); step();
    chk("alu_r3_data", 32'(rf_wdata), 32'h1234);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Load r5, then return collides with ALU r6
    set_in(0, 0, 0, 0, 1, 5, 0, 0); step();
    set_in(1, 6, 1, 0, 0, 0, 1, 'hBEEF); step();
    chk("collide_mem_rd", 32'(rf_rdst), 32'd5);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("collide_alu_rd", 32'(rf_rdst), 32'd6);
    step();

    // Fill queue r1..r4, query hazard, drain
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 0, 1, i, 0, 0); step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); rq_src = 4'd2;
    #1;
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    chk("full_hazard", 32'(hazard), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 'hA + i); step();
      chk("drain_order", 32'(rf_rdst), 32'(i + 1));
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("drain_hazard", 32'(hazard), 32'd0);
    rq_src = '0;

    // Link register and r0
    set_in(1, 15, 'h7777, 'h0040, 0, 0, 0, 0); step();
    chk("r15_pc", 32'(rf_pc), 32'h0040);
    set_in(1, 0, 'h5555, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Return into an empty queue, then same-cycle push+return bypass
    set_in(0, 0, 0, 0, 0, 0, 1, 'h9999); step();
    chk("err_set", 32'(ldq_err), 32'd1);
    set_in(0, 0, 0, 0, 1, 7, 1, 'h4242); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset with two loads pending
    set_in(0, 0, 0, 0, 1, 8, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 9, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    apply_reset();
    rq_src = 4'd8; rq_dst = 4'd9;
    step();
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 'h1111); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    apply_reset();
    step();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom, $urandom,
             $urandom_range(0, 2) == 0, $urandom_range(0, 15),
             (lq.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
      rq_src = 4'($urandom_range(0, 15));
      rq_dst = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
